brush_stamper: RTL and testbench
================================

Name: brush_stamper

Overview:
- Sits between the SPI command decoder and the pixel frame store in the drawing pipeline.
- Accepts one brush command per handshake: centre x/y, colour code and brush radius.
- Expands each command into a raster sequence of single-pixel write strobes covering the square brush footprint, clipped to the canvas.
- Each emitted write drives the frame store's write port (x, y, colour, enable).

Parameters:
- COORD_W, 8, coordinate width.
- COLOR_W, 3, colour code width.
- RAD_W, 3, width of the radius field.
- MAX_RADIUS, 3, largest honoured radius; larger requests clamp to this.
- CANVAS_W, 160, canvas width in pixels; valid x is 0..CANVAS_W-1.
- CANVAS_H, 120, canvas height in pixels; valid y is 0..CANVAS_H-1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  a command is presented.
- cmd_ready  out  1  block can accept a command.
- cmd_x  in  COORD_W  brush centre x.
- cmd_y  in  COORD_W  brush centre y.
- cmd_color  in  COLOR_W  colour code.
- cmd_radius  in  RAD_W  brush half-width.
- wr_en  out  1  pixel write strobe.
- wr_x  out  COORD_W  write x.
- wr_y  out  COORD_W  write y.
- wr_color  out  COLOR_W  write colour.
- busy  out  1  stamp in progress.
- done  out  1  one-cycle pulse; command fully retired.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high; it forces state IDLE immediately.
- Reset values: wr_en=0, wr_x=0, wr_y=0, wr_color=0, busy=0, done=0, cmd_ready=1.
- Output timing: all outputs except cmd_ready are registered. cmd_ready = (state==IDLE).
- Handshake: a command is accepted on the rising edge where cmd_valid && cmd_ready. cmd_valid while not ready is ignored; no queueing.
- Captured at accept: colour and clamped radius r = min(cmd_radius, MAX_RADIUS).
- Clip bounds, computed with COORD_W+1-bit signed arithmetic:
  - x0 = max(0, x-r), x1 = min(CANVAS_W-1, x+r).
  - y0 = max(0, y-r), y1 = min(CANVAS_H-1, y+r).
- Out-of-canvas centre: if cmd_x >= CANVAS_W or cmd_y >= CANVAS_H, the command is dropped. Go IDLE -> DONE with zero writes.
- State IDLE: cmd_ready=1, busy=0. On accept, go to STAMP (or to DONE if dropped). Load cx=x0, cy=y0.
- State STAMP: busy=1. Every cycle present wr_en=1 with (cx, cy, colour).
  - Raster order: x increments first. When cx==x1, cx returns to x0 and cy increments.
  - When cx==x1 && cy==y1, the next state is DONE.
- State DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- Write count: (x1-x0+1)*(y1-y0+1), issued on consecutive cycles with no gaps.
- Latency:
  - First wr_en is visible in the cycle after the accept edge.
  - done is high the cycle after the last wr_en.
  - cmd_ready returns the cycle after done.
  - Radius 0 gives accept at T, write at T+1, done at T+2, ready at T+3.
- Reset mid-stamp: wr_en drops immediately and remaining writes are abandoned; no done pulse.
- No frame-store backpressure: every wr_en is consumed the cycle it is asserted.
- Command inputs may change freely after accept; all command fields are captured at accept.

Decomposition:
- Shared package draw_pkg:
  - COORD_W, COLOR_W, CANVAS_W, CANVAS_H.
  - Colour-code enum shared with the colour decoder.
  - stamp_state_t {IDLE, STAMP, DONE}.
- One combinational sub-module, stamp_clip:
  - Inputs: centre and radius.
  - Outputs: x0, x1, y0, y1 and an out_of_canvas flag.
  - Unit-testable on its own.

Test Plan:
- Reset, then (10,20), colour 5, r=0 -> one wr_en at accept+1 with (10,20,5); done at accept+2; cmd_ready at accept+3.
- (50,50), colour 2, r=1 -> 9 consecutive writes (49,49),(50,49),(51,49),(49,50)...(51,51); busy high throughout; done once.
- Corner (0,0), r=2 -> 9 writes covering x,y in 0..2. Edge (159,119), r=3 -> 16 writes covering x 156..159, y 116..119.
- Centre (200,10), r=1 -> no wr_en; done pulses at accept+1; cmd_ready at accept+2.
- cmd_radius=7 at (80,60) -> clamps to 3, giving 49 writes over x 77..83, y 57..63. cmd_valid pulsed during STAMP -> ignored, still exactly 49 writes.
- Same command with reset asserted after the 10th write -> wr_en=0 and busy=0 immediately; cmd_ready=1; no done; no further writes after release.

Source files
------------

// File: rtl/draw_pkg.sv
// Shared definitions for the drawing pipeline.
//   COORD_W / COLOR_W       : pixel coordinate and colour code widths
//   CANVAS_W / CANVAS_H     : canvas size; valid x 0..CANVAS_W-1, y 0..CANVAS_H-1
//   color_t                 : colour codes shared with the colour decoder
//   stamp_state_t           : brush stamper sequencing states
package draw_pkg;

  localparam int COORD_W  = 8;
  localparam int COLOR_W  = 3;
  localparam int CANVAS_W = 160;
  localparam int CANVAS_H = 120;

  typedef enum logic [COLOR_W-1:0] {
    COLOR_BLACK   = 3'd0,
    COLOR_BLUE    = 3'd1,
    COLOR_GREEN   = 3'd2,
    COLOR_CYAN    = 3'd3,
    COLOR_RED     = 3'd4,
    COLOR_MAGENTA = 3'd5,
    COLOR_YELLOW  = 3'd6,
    COLOR_WHITE   = 3'd7
  } color_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STAMP = 2'd1,
    DONE  = 2'd2
  } stamp_state_t;

endpackage

// File: rtl/stamp_clip.sv
// Combinational brush footprint clipper.
// Clamps the radius to MAX_RADIUS and clips the square footprint around
// (x, y) to the canvas.
//   x, y          : brush centre
//   radius        : requested half-width
//   x0, x1        : first/last column of the clipped footprint
//   y0, y1        : first/last row of the clipped footprint
//   out_of_canvas : centre lies outside the canvas; command must be dropped
module stamp_clip
  import draw_pkg::*;
#(
  parameter int RAD_W      = 3,
  parameter int MAX_RADIUS = 3
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [RAD_W-1:0]   radius,
  output logic [COORD_W-1:0] x0,
  output logic [COORD_W-1:0] x1,
  output logic [COORD_W-1:0] y0,
  output logic [COORD_W-1:0] y1,
  output logic               out_of_canvas
);

  // One extra bit so that centre - radius can go negative.
  typedef logic signed [COORD_W:0] scoord_t;

  localparam scoord_t X_MAX = scoord_t'(CANVAS_W - 1);
  localparam scoord_t Y_MAX = scoord_t'(CANVAS_H - 1);

  logic [RAD_W-1:0] r_clamped;
  scoord_t          xs, ys, rs;
  scoord_t          x_lo, x_hi, y_lo, y_hi;

  assign r_clamped = (radius > RAD_W'(MAX_RADIUS)) ? RAD_W'(MAX_RADIUS) : radius;

  assign xs = scoord_t'(x);
  assign ys = scoord_t'(y);
  assign rs = scoord_t'(r_clamped);

  assign x_lo = xs - rs;
  assign x_hi = xs + rs;
  assign y_lo = ys - rs;
  assign y_hi = ys + rs;

  // A set sign bit means the low edge fell off the canvas: clip to 0.
  assign x0 = x_lo[COORD_W] ? '0 : x_lo[COORD_W-1:0];
  assign y0 = y_lo[COORD_W] ? '0 : y_lo[COORD_W-1:0];
  assign x1 = (x_hi > X_MAX) ? X_MAX[COORD_W-1:0] : x_hi[COORD_W-1:0];
  assign y1 = (y_hi > Y_MAX) ? Y_MAX[COORD_W-1:0] : y_hi[COORD_W-1:0];

  // The high-edge sums may wrap for off-canvas centres; those commands are
  // discarded through this flag, so the wrapped bounds are never used.
  assign out_of_canvas = (x >= COORD_W'(CANVAS_W)) || (y >= COORD_W'(CANVAS_H));

endmodule

// File: rtl/brush_stamper.sv
// Brush stamper: turns one brush command into a raster of single-pixel
// frame-store writes covering the clipped square footprint.
//   clk, reset     : clock, asynchronous active-high reset
//   cmd_valid/ready: command handshake (ready only while IDLE)
//   cmd_x, cmd_y   : brush centre
//   cmd_color      : colour code
//   cmd_radius     : brush half-width (clamped to MAX_RADIUS)
//   wr_en/x/y/color: frame-store write port, one pixel per cycle
//   busy           : stamp in progress
//   done           : one-cycle pulse when the command is retired
module brush_stamper
  import draw_pkg::*;
#(
  parameter int RAD_W      = 3,
  parameter int MAX_RADIUS = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [COORD_W-1:0] cmd_x,
  input  logic [COORD_W-1:0] cmd_y,
  input  logic [COLOR_W-1:0] cmd_color,
  input  logic [RAD_W-1:0]   cmd_radius,
  output logic               wr_en,
  output logic [COORD_W-1:0] wr_x,
  output logic [COORD_W-1:0] wr_y,
  output logic [COLOR_W-1:0] wr_color,
  output logic               busy,
  output logic               done
);

  stamp_state_t       state_reg, state_next;
  logic [COORD_W-1:0] cx_reg, cx_next;
  logic [COORD_W-1:0] cy_reg, cy_next;
  logic [COORD_W-1:0] x0_reg, x0_next;
  logic [COORD_W-1:0] x1_reg, x1_next;
  logic [COORD_W-1:0] y1_reg, y1_next;
  logic [COLOR_W-1:0] color_reg, color_next;
  logic               wr_en_reg, busy_reg, done_reg;

  logic [COORD_W-1:0] clip_x0, clip_x1, clip_y0, clip_y1;
  logic               clip_oob;

  stamp_clip #(
    .RAD_W      (RAD_W),
    .MAX_RADIUS (MAX_RADIUS)
  ) u_clip (
    .x             (cmd_x),
    .y             (cmd_y),
    .radius        (cmd_radius),
    .x0            (clip_x0),
    .x1            (clip_x1),
    .y0            (clip_y0),
    .y1            (clip_y1),
    .out_of_canvas (clip_oob)
  );

  assign cmd_ready = (state_reg == IDLE);

  // The raster counters are the write address, so wr_x/wr_y come straight
  // from registers and line up with the registered wr_en.
  assign wr_en    = wr_en_reg;
  assign wr_x     = cx_reg;
  assign wr_y     = cy_reg;
  assign wr_color = color_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;

  always_comb begin
    state_next = state_reg;
    cx_next    = cx_reg;
    cy_next    = cy_reg;
    x0_next    = x0_reg;
    x1_next    = x1_reg;
    y1_next    = y1_reg;
    color_next = color_reg;
    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          color_next = cmd_color;
          x0_next    = clip_x0;
          x1_next    = clip_x1;
          y1_next    = clip_y1;
          cx_next    = clip_x0;
          cy_next    = clip_y0;
          state_next = clip_oob ? DONE : STAMP;
        end
      end
      STAMP: begin
        if (cx_reg == x1_reg) begin
          if (cy_reg == y1_reg) begin
            state_next = DONE;
          end else begin
            cx_next = x0_reg;
            cy_next = cy_reg + 1'b1;
          end
        end else begin
          cx_next = cx_reg + 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cx_reg    <= '0;
      cy_reg    <= '0;
      x0_reg    <= '0;
      x1_reg    <= '0;
      y1_reg    <= '0;
      color_reg <= '0;
      wr_en_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cx_reg    <= cx_next;
      cy_reg    <= cy_next;
      x0_reg    <= x0_next;
      x1_reg    <= x1_next;
      y1_reg    <= y1_next;
      color_reg <= color_next;
      wr_en_reg <= (state_next == STAMP);
      busy_reg  <= (state_next == STAMP);
      done_reg  <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_brush_stamper.sv
// Scoreboard bench for brush_stamper: directed commands push their expected
// pixel writes and done pulse into a queue; a negedge monitor pops and
// compares each write/done the DUT presents.
module tb_brush_stamper;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_x, cmd_y;
  logic [2:0] cmd_color, cmd_radius;
  logic       wr_en;
  logic [7:0] wr_x, wr_y;
  logic [2:0] wr_color;
  logic       busy, done;

  typedef struct {
    bit is_done;
    int x;
    int y;
    int c;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  brush_stamper dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_x      (cmd_x),
    .cmd_y      (cmd_y),
    .cmd_color  (cmd_color),
    .cmd_radius (cmd_radius),
    .wr_en      (wr_en),
    .wr_x       (wr_x),
    .wr_y       (wr_y),
    .wr_color   (wr_color),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: every presented write or done pulse must match the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0) begin
      if (wr_en === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_write: got (%0d,%0d,%0d), expected no write", wr_x, wr_y, wr_color);
        end else begin
          e = exp_q.pop_front();
          if (e.is_done || wr_x != e.x || wr_y != e.y || wr_color != e.c || busy !== 1'b1 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL wr_pixel: got (%0d,%0d,%0d) busy=%0b done=%0b, expected %s (%0d,%0d,%0d) busy=1 done=0",
                     wr_x, wr_y, wr_color, busy, done, e.is_done ? "done" : "write", e.x, e.y, e.c);
          end
        end
      end
      if (done === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_done: got done=1, expected no done");
        end else begin
          e = exp_q.pop_front();
          if (!e.is_done || busy !== 1'b0 || wr_en !== 1'b0) begin
            n_bad++;
            $display("FAIL done_pulse: got done busy=%0b wr_en=%0b, expected %s with busy=0 wr_en=0",
                     busy, wr_en, e.is_done ? "done" : "write");
          end
        end
      end
    end
  end

  // One directed command. Bounds are hand-computed by the caller.
  task automatic run_cmd(input int x, input int y, input int c, input int r,
                         input int ex0, input int ex1, input int ey0, input int ey1,
                         input bit drop, input int pulse_at, input int abort_after);
    int   n;
    int   w;
    int   idx;
    exp_t e;
    n = drop ? 0 : (ex1 - ex0 + 1) * (ey1 - ey0 + 1);
    @(negedge clk);
    w = 0;
    while (cmd_ready !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("ready_wait", int'(cmd_ready), 1);
    cmd_valid  = 1'b1;
    cmd_x      = 8'(x);
    cmd_y      = 8'(y);
    cmd_color  = 3'(c);
    cmd_radius = 3'(r);
    if (!drop) begin
      for (int yy = ey0; yy <= ey1; yy++) begin
        for (int xx = ex0; xx <= ex1; xx++) begin
          e.is_done = 1'b0; e.x = xx; e.y = yy; e.c = c;
          exp_q.push_back(e);
        end
      end
    end
    e.is_done = 1'b1; e.x = 0; e.y = 0; e.c = 0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cmd_valid  = 1'b0;
    cmd_x      = 8'($urandom);
    cmd_y      = 8'($urandom);
    cmd_color  = 3'($urandom);
    cmd_radius = 3'($urandom);
    @(negedge clk);
    idx = 0;
    while (done !== 1'b1 && idx < 200) begin
      if (pulse_at > 0 && idx == pulse_at) begin
        cmd_valid  = 1'b1;
        cmd_x      = 8'd3;
        cmd_y      = 8'd3;
        cmd_radius = 3'd0;
      end else begin
        cmd_valid = 1'b0;
      end
      if (abort_after > 0 && idx == abort_after - 1) begin
        #2 reset = 1'b1;
        #1;
        check("abort_wr_en", int'(wr_en), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_ready", int'(cmd_ready), 1);
        check("abort_done", int'(done), 0);
        check("abort_writes_seen", n + 1 - exp_q.size(), abort_after);
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (60) @(negedge clk);
        check("abort_ready_after", int'(cmd_ready), 1);
        $display("cmd (%0d,%0d) col=%0d r=%0d aborted after %0d writes", x, y, c, r, abort_after);
        return;
      end
      @(negedge clk);
      idx++;
    end
    cmd_valid = 1'b0;
    check("done_latency", idx, n);
    check("ready_low_at_done", int'(cmd_ready), 0);
    @(negedge clk);
    check("ready_after_done", int'(cmd_ready), 1);
    check("done_one_cycle", int'(done), 0);
    $display("cmd (%0d,%0d) col=%0d r=%0d writes=%0d done_at=+%0d", x, y, c, r, n, idx + 1);
  endtask

  initial begin
    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_x      = '0;
    cmd_y      = '0;
    cmd_color  = '0;
    cmd_radius = '0;
    repeat (2) @(negedge clk);
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_wr_x", int'(wr_x), 0);
    check("rst_wr_y", int'(wr_y), 0);
    check("rst_wr_color", int'(wr_color), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_ready", int'(cmd_ready), 1);
    reset = 1'b0;

    //       x    y   c  r  x0   x1   y0   y1  drop pulse abort
    run_cmd( 10,  20, 5, 0,  10,  10,  20,  20, 0,   0,    0);
    run_cmd( 50,  50, 2, 1,  49,  51,  49,  51, 0,   0,    0);
    run_cmd(  0,   0, 3, 2,   0,   2,   0,   2, 0,   0,    0);
    run_cmd(159, 119, 6, 3, 156, 159, 116, 119, 0,   0,    0);
    run_cmd(200,  10, 1, 1,   0,   0,   0,   0, 1,   0,    0);
    run_cmd( 10, 130, 7, 2,   0,   0,   0,   0, 1,   0,    0);
    run_cmd( 80,  60, 4, 7,  77,  83,  57,  63, 0,   5,    0);
    run_cmd( 80,  60, 4, 7,  77,  83,  57,  63, 0,   0,   10);
    run_cmd(  1, 118, 1, 2,   0,   3, 116, 119, 0,   0,    0);

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
